// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronises the serial line, detects the start edge,
// samples each bit at mid-period and flags a bad stop bit as a framing error.
module uart_rx_frame #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int BPS_CNT = CLK_FREQ / BAUD;
    localparam int CW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

    localparam logic [CW-1:0] HALF_M1 = CW'(BPS_CNT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BPS_CNT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [2:0]    sync_q, sync_d;

    logic line;
    logic start_edge;

    // sync_q[0] and sync_q[1] form the synchroniser; sync_q[2] is the previous value for edge detect
    assign sync_d     = {sync_q[1:0], data_in};
    assign line       = sync_q[1];
    assign start_edge = sync_q[2] & ~sync_q[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == FULL_M1) ? '0 : cnt_q + CW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                if (start_edge) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    // a high line at mid-start means the edge was a glitch
                    state_d   = line ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    shift_d[bit_idx_q] = line;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            default: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (line) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            sync_q      <= 3'b111;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            sync_q      <= sync_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed serial frames, scoreboard of expected
// strobes popped by a monitor that also checks strobe latency.
module tb_uart_rx_frame;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int BPS      = CLK_FREQ / BAUD;
    localparam int LAT      = 3 + BPS / 2 + 9 * BPS;

    logic       clk;
    logic       rst;
    logic       data_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int n_checks;
    int n_pass;
    int cyc;

    // entry: bit 8 = framing error expected, bits 7:0 = expected rx_data
    logic [8:0] exp_q[$];
    int         start_q[$];
    logic [7:0] last_good;

    uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // driver: caller is positioned #1 after a rising edge
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_it,
                              input bit rst_at_bit4);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        if (expect_it) begin
            if (stop) begin
                exp_q.push_back({1'b0, b});
                last_good = b;
            end else begin
                exp_q.push_back({1'b1, last_good});
            end
            start_q.push_back(cyc);
        end
        for (int i = 0; i < 10; i++) begin
            data_in = bits[i];
            for (int j = 0; j < BPS; j++) begin
                if (rst_at_bit4 && i == 5 && j == 3) rst = 1'b0;
                @(posedge clk);
                #1;
                if (rst_at_bit4 && i == 5 && j == 3) begin
                    rst = 1'b1;
                    last_good = 8'h00;
                    check("reset_rx_data", rx_data == 8'h00, rx_data, 0);
                    check("reset_strobes", {rx_valid, frame_err, rx_busy} == 3'b000,
                          {rx_valid, frame_err, rx_busy}, 0);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        data_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst && (rx_valid || frame_err)) begin
            logic [8:0] e;
            int         s;
            check("exclusive_strobes", !(rx_valid && frame_err), {rx_valid, frame_err}, 0);
            check("busy_low_at_strobe", !rx_busy, rx_busy, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1'b0, {frame_err, rx_data}, 0);
            end else begin
                e = exp_q.pop_front();
                s = start_q.pop_front();
                check("strobe_kind", frame_err == e[8], frame_err, e[8]);
                check("rx_data", rx_data == e[7:0], rx_data, e[7:0]);
                check("latency", (cyc - s) >= LAT - 2 && (cyc - s) <= LAT + 2, cyc - s, LAT);
            end
        end
    end

    initial begin
        int busy_cnt;
        n_checks  = 0;
        n_pass    = 0;
        last_good = 8'h00;
        rst       = 1'b0;
        data_in   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("init_rx_data", rx_data == 8'h00, rx_data, 0);
        check("init_strobes", {rx_valid, frame_err, rx_busy} == 3'b000,
              {rx_valid, frame_err, rx_busy}, 0);
        rst = 1'b1;
        idle(5);

        // single byte
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        idle(15);

        // framing error, line held low afterwards
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        data_in = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        idle(20);

        // back-to-back frames
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        idle(15);

        // 3-clock glitch on an idle line
        data_in  = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) data_in = 1'b1;
            if (rx_busy) busy_cnt++;
        end
        check("glitch_busy_cycles", busy_cnt >= 4 && busy_cnt <= 6, busy_cnt, 5);
        check("glitch_idle", !rx_busy, rx_busy, 0);
        send_frame(8'h81, 1'b1, 1'b1, 1'b0);
        idle(15);

        // mid-frame reset during bit 4 of 8'hF0
        send_frame(8'hF0, 1'b1, 1'b0, 1'b1);
        idle(15);
        send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
        idle(120);

        check("all_strobes_seen", exp_q.size() == 0, exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
